ahblite_slave_mux: RTL and testbench
====================================

Name: ahblite_slave_mux

Overview:
- Return-path counterpart of the AHB-Lite address decoder.
- Takes the decoder's per-port HSEL lines in the address phase and registers which port owns the data phase.
- Steers that port's HRDATA/HREADYOUT/HRESP back to the single master.
- Contains an integrated default slave that answers unmapped accesses with a two-cycle AHB ERROR response.

Parameters:
- Port0_en, 1, RAMCODE port (0x0000_0000-0x0000_FFFF) enabled; if 0, P0_HSEL is ignored and such accesses go to the default slave.
- Port1_en, 1, RAMDATA port (0x2000_0000-0x2000_FFFF) enabled; same rule.
- Port2_en, 1, APB bridge port (0x4000_0000 region) enabled; same rule.

Ports:
- HCLK  input  1  bus clock
- HRESET  input  1  asynchronous, active-high reset
- HREADY  input  1  bus-level HREADY (this block's HREADYOUT fed back by the interconnect)
- HTRANS  input  2  master transfer type
- HADDR  input  32  master address (used only by the optional feature)
- P0_HSEL / P1_HSEL / P2_HSEL  input  1 each  decoder selects, address phase
- Pn_HREADYOUT  input  1  per-port slave ready (n=0..2)
- Pn_HRESP  input  1  per-port slave response (n=0..2)
- Pn_HRDATA  input  32  per-port read data (n=0..2)
- ERR_CLR  input  1  clears the captured error (optional feature)
- HREADYOUT  output  1  muxed ready to master
- HRESP  output  1  muxed response to master
- HRDATA  output  32  muxed read data to master
- ERR_VALID  output  1  sticky error flag (optional feature)
- ERR_ADDR  output  32  captured faulting address (optional feature)

Behaviour:
- Effective select: Sn = Pn_HSEL & Port_en[n]. At most one Sn is high (decoder guarantee); priority if violated is P0 > P1 > P2.
- Data-phase owner register dsel ∈ {NONE, P0, P1, P2, DEF}.
  - Updates only on rising HCLK with HREADY=1.
  - Next value: the asserted Sn port, else DEF if HTRANS[1]=1 (NONSEQ/SEQ), else NONE (IDLE/BUSY to an unmapped address).
  - Holds while HREADY=0.
- Output mux, combinational from dsel:
  - P0..P2: forward that port's HRDATA/HREADYOUT/HRESP.
  - NONE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - DEF: driven by the default-slave FSM, HRDATA=0.
- Default-slave FSM states IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when DEF is captured (HREADY=1 & no Sn & HTRANS[1]).
  - ERR1: HREADYOUT=0, HRESP=1; unconditionally -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; -> ERR1 if another unmapped NONSEQ/SEQ is captured this cycle, else IDLE.
  - IDLE with dsel=DEF does not occur.
- Latency: zero-wait OKAY for NONE; exactly 2 data-phase cycles for every unmapped active transfer; pass-through for mapped ports with no added delay.
- Back-to-back transfers: a new address phase is sampled on the same edge that completes the previous data phase (HREADY=1). Switching port between consecutive transfers is glitch-free at the edge.
- Reset (async, HRESET=1): dsel=NONE, FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, ERR_VALID=0, ERR_ADDR=0. Reset mid-ERR1/ERR2 aborts the response immediately.
- Mapped slave wait states: HREADYOUT follows the slave; dsel is held until the slave completes.

Optional Feature:
- Macro: AHB_MUX_ERR_CAPTURE_EN.
- Defined:
  - On the first DEF capture while ERR_VALID=0, ERR_ADDR<=HADDR and ERR_VALID<=1.
  - Later errors do not overwrite ERR_ADDR.
  - ERR_CLR=1 clears both flags on the next edge; a simultaneous new error wins (capture, ERR_VALID stays 1).
- Undefined: ERR_VALID and ERR_ADDR tie to 0; ERR_CLR and HADDR are unused.

Decomposition:
- Package ahblite_pkg:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HRESP_OKAY=0, HRESP_ERROR=1
  - dsel encoding constants
  - default-slave FSM state encoding
- Sub-module ahblite_default_slave (FSM plus its HREADYOUT/HRESP), instantiated once. The mux and dsel register stay in the top.

Test Plan:
- Reset: assert HRESET mid-run -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately, ERR_VALID=0.
- Mapped read: NONSEQ with P1_HSEL=1, P1_HRDATA=0xDEAD_BEEF, one slave wait -> HREADYOUT low 1 cycle, then HRDATA=0xDEAD_BEEF with HRESP=0.
- Unmapped access: NONSEQ to 0x6000_0000 (no HSEL) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; with the macro, ERR_ADDR=0x6000_0000 and ERR_VALID=1.
- Disabled port: Port2_en=0, NONSEQ with P2_HSEL=1 -> two-cycle ERROR; P2 data ignored.
- Back-to-back: P0 read, then unmapped SEQ, then P2 read, then IDLE -> correct data per phase, one ERROR pair, IDLE gets zero-wait OKAY.
- Error capture: two unmapped accesses (0x6000_0000, then 0x7000_0000) -> ERR_ADDR stays 0x6000_0000; ERR_CLR together with a third error at 0x8000_0000 -> ERR_VALID=1, ERR_ADDR=0x8000_0000.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings for the slave return-path mux and its default slave.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_P0   = 3'd1,
    DSEL_P1   = 3'd2,
    DSEL_P2   = 3'd3,
    DSEL_DEF  = 3'd4
  } dsel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ carry data; IDLE and BUSY never need a response beyond OKAY.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers every captured unmapped active transfer with a
// two-cycle AHB ERROR (ERR1: not ready, ERR2: ready), back-to-back capable.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_capture,
  output logic o_hreadyout,
  output logic o_hresp
);

  ds_state_e r_state;
  ds_state_e w_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= DS_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    unique case (r_state)
      DS_IDLE: begin
        if (i_capture) w_next = DS_ERR1;
      end
      DS_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        w_next      = DS_ERR2;
      end
      DS_ERR2: begin
        o_hresp = HRESP_ERROR;
        // The completing edge may already carry the next unmapped address phase.
        w_next  = i_capture ? DS_ERR1 : DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite return-path mux: registers the data-phase owner and steers its
// response to the master. Optional error capture under AHB_MUX_ERR_CAPTURE_EN.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic        ERR_CLR,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        ERR_VALID,
  output logic [31:0] ERR_ADDR
);

  logic  w_s0, w_s1, w_s2;
  logic  w_active;
  logic  w_def_cap;
  logic  w_def_hreadyout, w_def_hresp;
  dsel_e w_next_dsel;
  dsel_e r_dsel;

  // Disabled ports are treated as unmapped so the default slave answers them.
  assign w_s0      = P0_HSEL & Port0_en;
  assign w_s1      = P1_HSEL & Port1_en;
  assign w_s2      = P2_HSEL & Port2_en;
  assign w_active  = htrans_active(HTRANS);
  assign w_def_cap = HREADY & ~(w_s0 | w_s1 | w_s2) & w_active;

  always_comb begin
    if (w_s0)          w_next_dsel = DSEL_P0;
    else if (w_s1)     w_next_dsel = DSEL_P1;
    else if (w_s2)     w_next_dsel = DSEL_P2;
    else if (w_active) w_next_dsel = DSEL_DEF;
    else               w_next_dsel = DSEL_NONE;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      r_dsel <= DSEL_NONE;
    else if (HREADY) r_dsel <= w_next_dsel;
  end

  ahblite_default_slave u_default_slave (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_capture   (w_def_cap),
    .o_hreadyout (w_def_hreadyout),
    .o_hresp     (w_def_hresp)
  );

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    unique case (r_dsel)
      DSEL_P0: begin
        HREADYOUT = P0_HREADYOUT;
        HRESP     = P0_HRESP;
        HRDATA    = P0_HRDATA;
      end
      DSEL_P1: begin
        HREADYOUT = P1_HREADYOUT;
        HRESP     = P1_HRESP;
        HRDATA    = P1_HRDATA;
      end
      DSEL_P2: begin
        HREADYOUT = P2_HREADYOUT;
        HRESP     = P2_HRESP;
        HRDATA    = P2_HRDATA;
      end
      DSEL_DEF: begin
        HREADYOUT = w_def_hreadyout;
        HRESP     = w_def_hresp;
      end
      default: ;
    endcase
  end

`ifdef AHB_MUX_ERR_CAPTURE_EN
  logic        r_err_valid;
  logic [31:0] r_err_addr;

  // A new fault on the clearing edge is kept rather than lost.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_def_cap && (!r_err_valid || ERR_CLR)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= HADDR;
    end else if (ERR_CLR) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end
  end

  assign ERR_VALID = r_err_valid;
  assign ERR_ADDR  = r_err_addr;
`else
  logic w_unused;
  assign w_unused  = ^{ERR_CLR, HADDR};
  assign ERR_VALID = 1'b0;
  assign ERR_ADDR  = '0;
`endif

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Randomized and directed bench for ahblite_slave_mux using a transaction-level
// response model; a second instance has port 2 disabled.
module tb_ahblite_slave_mux;

`ifdef AHB_MUX_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam int K_DEF  = 3;
  localparam int K_NONE = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        P0_HSEL, P1_HSEL, P2_HSEL;
  logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT;
  logic        P0_HRESP, P1_HRESP, P2_HRESP;
  logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA;
  logic        ERR_CLR;

  logic        rdy_a, rsp_a, ev_a, rdy_b, rsp_b, ev_b;
  logic [31:0] dat_a, ea_a, dat_b, ea_b;

  always #5 HCLK = ~HCLK;

  ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1)) u_dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HREADY(rdy_a), .HTRANS(HTRANS), .HADDR(HADDR),
    .P0_HSEL(P0_HSEL), .P1_HSEL(P1_HSEL), .P2_HSEL(P2_HSEL),
    .P0_HREADYOUT(P0_HREADYOUT), .P1_HREADYOUT(P1_HREADYOUT), .P2_HREADYOUT(P2_HREADYOUT),
    .P0_HRESP(P0_HRESP), .P1_HRESP(P1_HRESP), .P2_HRESP(P2_HRESP),
    .P0_HRDATA(P0_HRDATA), .P1_HRDATA(P1_HRDATA), .P2_HRDATA(P2_HRDATA),
    .ERR_CLR(ERR_CLR), .HREADYOUT(rdy_a), .HRESP(rsp_a), .HRDATA(dat_a),
    .ERR_VALID(ev_a), .ERR_ADDR(ea_a)
  );

  ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b0)) u_dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HREADY(rdy_b), .HTRANS(HTRANS), .HADDR(HADDR),
    .P0_HSEL(P0_HSEL), .P1_HSEL(P1_HSEL), .P2_HSEL(P2_HSEL),
    .P0_HREADYOUT(P0_HREADYOUT), .P1_HREADYOUT(P1_HREADYOUT), .P2_HREADYOUT(P2_HREADYOUT),
    .P0_HRESP(P0_HRESP), .P1_HRESP(P1_HRESP), .P2_HRESP(P2_HRESP),
    .P0_HRDATA(P0_HRDATA), .P1_HRDATA(P1_HRDATA), .P2_HRDATA(P2_HRDATA),
    .ERR_CLR(ERR_CLR), .HREADYOUT(rdy_b), .HRESP(rsp_b), .HRDATA(dat_b),
    .ERR_VALID(ev_b), .ERR_ADDR(ea_b)
  );

  typedef struct {
    logic [1:0]  trans;
    logic [2:0]  sel;
    logic [31:0] addr;
    int          waits;
    logic [31:0] data;
    logic        resp;
    bit          clr;
  } xfer_t;

  // obs/exp layout: {HREADYOUT, HRESP, HRDATA[31:0], ERR_VALID, ERR_ADDR[31:0]}
  typedef struct {
    logic [66:0] obs;
    logic [66:0] exp;
  } cyc_t;

  cyc_t        cq[$];
  int          total = 0;
  int          bad   = 0;
  int          cur_kind;
  xfer_t       cur_x;
  bit          use_b;
  bit [2:0]    en;
  logic        m_ev;
  logic [31:0] m_ea;

  function automatic xfer_t mk(input logic [1:0] t, input logic [2:0] s, input logic [31:0] a,
                               input int w, input logic [31:0] d, input bit c);
    xfer_t x;
    x.trans = t; x.sel = s; x.addr = a; x.waits = w; x.data = d; x.resp = 1'b0; x.clr = c;
    return x;
  endfunction

  // Owner of the data phase: lowest enabled selected port, else default slave
  // for an active transfer, else nobody.
  function automatic int classify(input xfer_t x);
    logic [2:0] s;
    s = x.sel & en;
    if (s[0]) return 0;
    if (s[1]) return 1;
    if (s[2]) return 2;
    if (x.trans[1]) return K_DEF;
    return K_NONE;
  endfunction

  task automatic do_reset();
    HRESET = 1'b1;
    HTRANS = 2'b00; HADDR = '0; ERR_CLR = 1'b0;
    {P2_HSEL, P1_HSEL, P0_HSEL} = 3'b000;
    {P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT} = 3'b111;
    {P2_HRESP, P1_HRESP, P0_HRESP} = 3'b000;
    P0_HRDATA = '0; P1_HRDATA = '0; P2_HRDATA = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    cur_kind = K_NONE;
    m_ev = 1'b0;
    m_ea = '0;
  endtask

  // Present one address phase while the previous transfer's data phase runs.
  task automatic issue(input xfer_t x);
    int          ncyc;
    int          kind;
    logic [2:0]  rdy, rsp;
    logic [31:0] dat [3];
    logic        e_rdy, e_rsp;
    logic [31:0] e_dat;
    cyc_t        c_;
    ncyc = (cur_kind < 3) ? cur_x.waits + 1 : ((cur_kind == K_DEF) ? 2 : 1);
    for (int c = 0; c < ncyc; c++) begin
      HTRANS = x.trans;
      {P2_HSEL, P1_HSEL, P0_HSEL} = x.sel;
      HADDR = x.addr;
      ERR_CLR = x.clr && (c == ncyc - 1);
      for (int p = 0; p < 3; p++) begin
        rdy[p] = 1'($urandom);
        rsp[p] = 1'($urandom);
        dat[p] = $urandom;
      end
      e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
      if (cur_kind < 3) begin
        rdy[cur_kind] = (c == ncyc - 1);
        rsp[cur_kind] = cur_x.resp;
        dat[cur_kind] = cur_x.data;
        e_rdy = (c == ncyc - 1);
        e_rsp = cur_x.resp;
        e_dat = cur_x.data;
      end else if (cur_kind == K_DEF) begin
        e_rdy = (c == 1);
        e_rsp = 1'b1;
      end
      {P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT} = rdy;
      {P2_HRESP, P1_HRESP, P0_HRESP} = rsp;
      P0_HRDATA = dat[0]; P1_HRDATA = dat[1]; P2_HRDATA = dat[2];
      @(negedge HCLK);
      c_.exp = {e_rdy, e_rsp, e_dat, m_ev, m_ea};
      c_.obs = use_b ? {rdy_b, rsp_b, dat_b, ev_b, ea_b} : {rdy_a, rsp_a, dat_a, ev_a, ea_a};
      cq.push_back(c_);
      @(posedge HCLK);
      #1;
    end
    kind = classify(x);
    if (CAP) begin
      if (kind == K_DEF && (!m_ev || x.clr)) begin
        m_ev = 1'b1;
        m_ea = x.addr;
      end else if (x.clr) begin
        m_ev = 1'b0;
        m_ea = '0;
      end
    end
    ERR_CLR = 1'b0;
    cur_kind = kind;
    cur_x = x;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge HCLK);
    total++;
    if ({rdy_a, rsp_a, dat_a, ev_a, ea_a} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_a got=%h want=%h", {rdy_a, rsp_a, dat_a, ev_a, ea_a}, {1'b1, 66'h0});
    end
    total++;
    if ({rdy_b, rsp_b, dat_b, ev_b, ea_b} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_b got=%h want=%h", {rdy_b, rsp_b, dat_b, ev_b, ea_b}, {1'b1, 66'h0});
    end
    @(posedge HCLK);
    #1;
    HTRANS = 2'b10; HADDR = 32'h6000_0000;
    @(posedge HCLK);
    #1 HTRANS = 2'b00;
    @(negedge HCLK);
    total++;
    if ({rdy_a, rsp_a, ev_a} !== {1'b0, 1'b1, CAP}) begin
      bad++;
      $display("FAIL err1_before_reset got=%b want=%b", {rdy_a, rsp_a, ev_a}, {1'b0, 1'b1, CAP});
    end
    #1 HRESET = 1'b1;
    #1;
    total++;
    if ({rdy_a, rsp_a, dat_a, ev_a} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_err1 got=%h want=%h", {rdy_a, rsp_a, dat_a, ev_a}, {1'b1, 34'h0});
    end
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    cur_kind = K_NONE; m_ev = 1'b0; m_ea = '0;
  endtask

  task automatic test_mapped_read();
    do_reset();
    use_b = 1'b0; en = 3'b111; cq.delete();
    issue(mk(2'b10, 3'b010, 32'h2000_0010, 1, 32'hDEAD_BEEF, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    foreach (cq[i]) begin
      total++;
      if (cq[i].obs !== cq[i].exp) begin
        bad++;
        $display("FAIL mapped_read cyc%0d got=%h want=%h", i, cq[i].obs, cq[i].exp);
      end
    end
    total++;
    if ({cq[1].obs[66], cq[2].obs[66:33]} !== {1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL mapped_read_wait got=%h want=%h",
               {cq[1].obs[66], cq[2].obs[66:33]}, {1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_unmapped();
    do_reset();
    use_b = 1'b0; en = 3'b111; cq.delete();
    issue(mk(2'b10, 3'b000, 32'h6000_0000, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    foreach (cq[i]) begin
      total++;
      if (cq[i].obs !== cq[i].exp) begin
        bad++;
        $display("FAIL unmapped cyc%0d got=%h want=%h", i, cq[i].obs, cq[i].exp);
      end
    end
    total++;
    if ({cq[1].obs[66:65], cq[2].obs[66:65], cq[3].obs[66:65]} !== 6'b01_11_10) begin
      bad++;
      $display("FAIL unmapped_pair got=%b want=011110",
               {cq[1].obs[66:65], cq[2].obs[66:65], cq[3].obs[66:65]});
    end
    total++;
    if ({ev_a, ea_a} !== {CAP, (CAP ? 32'h6000_0000 : 32'h0)}) begin
      bad++;
      $display("FAIL unmapped_capture got=%h want=%h", {ev_a, ea_a},
               {CAP, (CAP ? 32'h6000_0000 : 32'h0)});
    end
  endtask

  task automatic test_disabled_port();
    do_reset();
    use_b = 1'b1; en = 3'b011; cq.delete();
    issue(mk(2'b10, 3'b100, 32'h4000_0100, 0, 32'h1234_5678, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    foreach (cq[i]) begin
      total++;
      if (cq[i].obs !== cq[i].exp) begin
        bad++;
        $display("FAIL disabled_port cyc%0d got=%h want=%h", i, cq[i].obs, cq[i].exp);
      end
    end
    total++;
    if ({cq[1].obs[66:33], cq[2].obs[66:33]} !== {2'b01, 32'h0, 2'b11, 32'h0}) begin
      bad++;
      $display("FAIL disabled_port_err got=%h want=%h",
               {cq[1].obs[66:33], cq[2].obs[66:33]}, {2'b01, 32'h0, 2'b11, 32'h0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    use_b = 1'b0; en = 3'b111; cq.delete();
    issue(mk(2'b10, 3'b001, 32'h0000_0040, 0, 32'hA5A5_0001, 1'b0));
    issue(mk(2'b11, 3'b000, 32'h5000_0000, 0, 32'h0, 1'b0));
    issue(mk(2'b10, 3'b100, 32'h4000_0008, 1, 32'h0BAD_F00D, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    foreach (cq[i]) begin
      total++;
      if (cq[i].obs !== cq[i].exp) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", i, cq[i].obs, cq[i].exp);
      end
    end
  endtask

  task automatic test_err_capture();
    do_reset();
    use_b = 1'b0; en = 3'b111; cq.delete();
    issue(mk(2'b10, 3'b000, 32'h6000_0000, 0, 32'h0, 1'b0));
    issue(mk(2'b10, 3'b000, 32'h7000_0000, 0, 32'h0, 1'b0));
    issue(mk(2'b10, 3'b000, 32'h8000_0000, 0, 32'h0, 1'b1));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
    foreach (cq[i]) begin
      total++;
      if (cq[i].obs !== cq[i].exp) begin
        bad++;
        $display("FAIL err_capture cyc%0d got=%h want=%h", i, cq[i].obs, cq[i].exp);
      end
    end
    total++;
    if (cq[3].obs[31:0] !== (CAP ? 32'h6000_0000 : 32'h0)) begin
      bad++;
      $display("FAIL err_keep_first got=%h want=%h", cq[3].obs[31:0], (CAP ? 32'h6000_0000 : 32'h0));
    end
    total++;
    if ({ev_a, ea_a} !== {CAP, (CAP ? 32'h8000_0000 : 32'h0)}) begin
      bad++;
      $display("FAIL err_clr_vs_new got=%h want=%h", {ev_a, ea_a},
               {CAP, (CAP ? 32'h8000_0000 : 32'h0)});
    end
  endtask

  task automatic test_random();
    xfer_t x;
    for (int d = 0; d < 2; d++) begin
      do_reset();
      use_b = (d == 1); en = (d == 1) ? 3'b011 : 3'b111; cq.delete();
      for (int n = 0; n < 150; n++) begin
        x.trans = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) x.sel = 3'($urandom_range(0, 7));
        else x.sel = (3'b001 << $urandom_range(0, 3));
        x.addr  = $urandom;
        x.waits = $urandom_range(0, 2);
        x.data  = $urandom;
        x.resp  = 1'($urandom);
        x.clr   = ($urandom_range(0, 9) == 0);
        issue(x);
      end
      issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
      issue(mk(2'b00, 3'b000, 32'h0, 0, 32'h0, 1'b0));
      foreach (cq[i]) begin
        total++;
        if (cq[i].obs !== cq[i].exp) begin
          bad++;
          $display("FAIL random_dut%0d cyc%0d got=%h want=%h", d, i, cq[i].obs, cq[i].exp);
        end
      end
    end
  endtask

  initial begin
    HRESET = 1'b1;
    use_b = 1'b0;
    en = 3'b111;
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_disabled_port();
    test_back_to_back();
    test_err_capture();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
